// File: rtl/pc_pkg.sv
// Shared program-counter path definitions: address width, stack depth and
// the stack operation encoding used by the call stack and PC-op decoder.
package pc_pkg;

  localparam int unsigned PC_W      = 12;
  localparam int unsigned STK_DEPTH = 16;

  typedef logic [PC_W-1:0] pc_t;

  typedef enum logic [1:0] {
    STK_NOP  = 2'd0,
    STK_PUSH = 2'd1,
    STK_POP  = 2'd2,
    STK_REPL = 2'd3
  } stk_op_e;

  // Raw decode of the push/pop strobes; empty/full qualification is left to the user.
  function automatic stk_op_e stk_decode(input logic push, input logic pop);
    stk_op_e op;
    case ({push, pop})
      2'b10:   op = STK_PUSH;
      2'b01:   op = STK_POP;
      2'b11:   op = STK_REPL;
      default: op = STK_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/call_stack_mem.sv
// DEPTH x W register file: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module call_stack_mem #(
  parameter int unsigned W     = 12,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/call_stack.sv
// LIFO return-address stack feeding the next-PC stk_i input, with sticky
// overflow/underflow flags. Define CALL_STACK_FLAGS_EN to also save zero/carry per entry.
module call_stack
  import pc_pkg::*;
#(
  parameter int unsigned PC_W  = pc_pkg::PC_W,
  parameter int unsigned DEPTH = pc_pkg::STK_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [PC_W-1:0]            push_data_i,
`ifdef CALL_STACK_FLAGS_EN
  input  logic                       zero_i,
  input  logic                       carry_i,
  output logic                       zero_o,
  output logic                       carry_o,
`endif
  output logic [PC_W-1:0]            stk_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] depth_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);

  localparam int unsigned SP_W = $clog2(DEPTH + 1);
  localparam int unsigned AW   = $clog2(DEPTH);
`ifdef CALL_STACK_FLAGS_EN
  localparam int unsigned ENT_W = PC_W + 2;
`else
  localparam int unsigned ENT_W = PC_W;
`endif

  logic [SP_W-1:0]  sp_q, sp_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             empty, full;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    raddr;
  logic [ENT_W-1:0] wdata;
  logic [ENT_W-1:0] rdata;
  stk_op_e          op;

  assign empty = (sp_q == '0);
  assign full  = (sp_q == SP_W'(DEPTH));
  assign op    = stk_decode(push_i, pop_i);

`ifdef CALL_STACK_FLAGS_EN
  assign wdata = {zero_i, carry_i, push_data_i};
`else
  assign wdata = push_data_i;
`endif

  // Pointer/flag next state and write-port control; reset discards the op.
  always_comb begin
    sp_d  = sp_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    we    = 1'b0;
    waddr = AW'(sp_q);
    case (op)
      STK_PUSH: begin
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          we    = 1'b1;
          waddr = AW'(sp_q);
          sp_d  = sp_q + SP_W'(1);
        end
      end
      STK_POP: begin
        if (empty) begin
          unf_d = 1'b1;
        end else begin
          sp_d = sp_q - SP_W'(1);
        end
      end
      STK_REPL: begin
        // Empty stack: behaves as a plain push (DEPTH >= 2, so never full here).
        we = 1'b1;
        if (empty) begin
          waddr = '0;
          sp_d  = SP_W'(1);
        end else begin
          waddr = AW'(sp_q - SP_W'(1));
        end
      end
      default: begin
        sp_d = sp_q;
      end
    endcase
    if (rst_i) begin
      we = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign raddr = AW'(sp_q - SP_W'(1));

  call_stack_mem #(
    .W     (ENT_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  assign stk_o       = empty ? '0 : rdata[PC_W-1:0];
  assign empty_o     = empty;
  assign full_o      = full;
  assign depth_o     = sp_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

`ifdef CALL_STACK_FLAGS_EN
  assign zero_o  = empty ? 1'b0 : rdata[PC_W+1];
  assign carry_o = empty ? 1'b0 : rdata[PC_W];
`endif

endmodule

// File: tb/tb_call_stack.sv
// Self-checking bench for call_stack: directed scenarios plus a randomized
// run compared against a queue-based LIFO reference.
module tb_call_stack;
  import pc_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned DW    = $clog2(DEPTH + 1);

  logic          clk_i;
  logic          rst_i;
  logic          push_i;
  logic          pop_i;
  pc_t           push_data_i;
  pc_t           stk_o;
  logic          empty_o;
  logic          full_o;
  logic [DW-1:0] depth_o;
  logic          overflow_o;
  logic          underflow_o;
`ifdef CALL_STACK_FLAGS_EN
  logic          zero_i;
  logic          carry_i;
  logic          zero_o;
  logic          carry_o;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: a plain LIFO of {zero, carry, pc} plus sticky flags.
  logic [13:0] m_q[$];
  logic        m_ovf;
  logic        m_unf;

  call_stack #(.PC_W(12), .DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push_i),
    .pop_i       (pop_i),
    .push_data_i (push_data_i),
`ifdef CALL_STACK_FLAGS_EN
    .zero_i      (zero_i),
    .carry_i     (carry_i),
    .zero_o      (zero_o),
    .carry_o     (carry_o),
`endif
    .stk_o       (stk_o),
    .empty_o     (empty_o),
    .full_o      (full_o),
    .depth_o     (depth_o),
    .overflow_o  (overflow_o),
    .underflow_o (underflow_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Apply one cycle of stimulus, then advance the reference model.
  task automatic step(input logic rst, input logic push, input logic pop,
                      input pc_t d, input logic z, input logic c);
    rst_i       = rst;
    push_i      = push;
    pop_i       = pop;
    push_data_i = d;
`ifdef CALL_STACK_FLAGS_EN
    zero_i      = z;
    carry_i     = c;
`endif
    @(posedge clk_i);
    #1;
    rst_i  = 1'b0;
    push_i = 1'b0;
    pop_i  = 1'b0;
    if (rst) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (push && pop) begin
      if (m_q.size() == 0) m_q.push_back({z, c, d});
      else m_q[m_q.size()-1] = {z, c, d};
    end else if (push) begin
      if (m_q.size() == DEPTH) m_ovf = 1'b1;
      else m_q.push_back({z, c, d});
    end else if (pop) begin
      if (m_q.size() == 0) m_unf = 1'b1;
      else void'(m_q.pop_back());
    end
  endtask

  function automatic logic [13:0] m_top();
    logic [13:0] t;
    t = '0;
    if (m_q.size() != 0) t = m_q[m_q.size()-1];
    return t;
  endfunction

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    checks++; if (stk_o !== 12'h000) begin errors++; $display("FAIL reset_stk: got %h expected 000", stk_o); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty_o); end
    checks++; if (depth_o !== 5'd0) begin errors++; $display("FAIL reset_depth: got %0d expected 0", depth_o); end
    checks++; if (overflow_o !== 1'b0 || underflow_o !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got ovf=%b unf=%b expected 0 0", overflow_o, underflow_o);
    end
  endtask

  task automatic test_push_pop_order();
    pc_t exp_top [3];
    exp_top[0] = 12'h007; exp_top[1] = 12'h002; exp_top[2] = 12'h000;
    step(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 12'h002, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 12'h007, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 12'h10A, 1'b0, 1'b0);
    checks++; if (stk_o !== 12'h10A) begin errors++; $display("FAIL order_top: got %h expected 10a", stk_o); end
    checks++; if (depth_o !== 5'd3) begin errors++; $display("FAIL order_depth: got %0d expected 3", depth_o); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0);
      checks++;
      if (stk_o !== exp_top[i]) begin
        errors++; $display("FAIL order_pop%0d: got %h expected %h", i, stk_o, exp_top[i]);
      end
    end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL order_empty: got %b expected 1", empty_o); end
  endtask

  task automatic test_fill_overflow();
    step(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    for (int i = 1; i <= 16; i++) step(1'b0, 1'b1, 1'b0, 12'(i), 1'b0, 1'b0);
    checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL fill_full: got %b expected 1", full_o); end
    step(1'b0, 1'b1, 1'b0, 12'h0FF, 1'b0, 1'b0);
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow_o); end
    checks++; if (stk_o !== 12'h010) begin errors++; $display("FAIL ovf_top: got %h expected 010", stk_o); end
    checks++; if (depth_o !== 5'd16) begin errors++; $display("FAIL ovf_depth: got %0d expected 16", depth_o); end
    // Drain and confirm the overflowing push corrupted nothing.
    for (int i = 16; i >= 1; i--) begin
      checks++;
      if (stk_o !== 12'(i)) begin
        errors++; $display("FAIL drain_%0d: got %h expected %h", i, stk_o, 12'(i));
      end
      step(1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0);
    end
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow_o); end
  endtask

  task automatic test_underflow();
    step(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0);
    checks++; if (underflow_o !== 1'b1) begin errors++; $display("FAIL unf_flag: got %b expected 1", underflow_o); end
    checks++; if (depth_o !== 5'd0) begin errors++; $display("FAIL unf_depth: got %0d expected 0", depth_o); end
    step(1'b0, 1'b1, 1'b0, 12'h055, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 12'h066, 1'b0, 1'b0);
    checks++; if (underflow_o !== 1'b1) begin errors++; $display("FAIL unf_sticky: got %b expected 1", underflow_o); end
    checks++; if (stk_o !== 12'h066) begin errors++; $display("FAIL unf_push: got %h expected 066", stk_o); end
    step(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    checks++; if (underflow_o !== 1'b0) begin errors++; $display("FAIL unf_clear: got %b expected 0", underflow_o); end
  endtask

  task automatic test_simultaneous();
    step(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 12'h002, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 12'h007, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 12'h3FF, 1'b0, 1'b0);
    checks++; if (stk_o !== 12'h3FF) begin errors++; $display("FAIL repl_top: got %h expected 3ff", stk_o); end
    checks++; if (depth_o !== 5'd2) begin errors++; $display("FAIL repl_depth: got %0d expected 2", depth_o); end
    step(1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0);
    checks++; if (stk_o !== 12'h002) begin errors++; $display("FAIL repl_below: got %h expected 002", stk_o); end
    step(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 12'h123, 1'b0, 1'b0);
    checks++; if (depth_o !== 5'd1) begin errors++; $display("FAIL repl_empty_depth: got %0d expected 1", depth_o); end
    checks++; if (underflow_o !== 1'b0) begin errors++; $display("FAIL repl_empty_unf: got %b expected 0", underflow_o); end
    checks++; if (stk_o !== 12'h123) begin errors++; $display("FAIL repl_empty_top: got %h expected 123", stk_o); end
  endtask

  task automatic test_reset_mid_op();
    step(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 12'(12'h0A0 + i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 12'h0AA, 1'b0, 1'b0);
    checks++; if (depth_o !== 5'd0) begin errors++; $display("FAIL rstmid_depth: got %0d expected 0", depth_o); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL rstmid_empty: got %b expected 1", empty_o); end
    checks++; if (stk_o !== 12'h000) begin errors++; $display("FAIL rstmid_top: got %h expected 000", stk_o); end
`ifdef CALL_STACK_FLAGS_EN
    checks++; if (zero_o !== 1'b0 || carry_o !== 1'b0) begin
      errors++; $display("FAIL flags_empty: got z=%b c=%b expected 0 0", zero_o, carry_o);
    end
    step(1'b0, 1'b1, 1'b0, 12'h020, 1'b1, 1'b0);
    checks++; if (zero_o !== 1'b1 || carry_o !== 1'b0) begin
      errors++; $display("FAIL flags_push: got z=%b c=%b expected 1 0", zero_o, carry_o);
    end
    step(1'b0, 1'b1, 1'b1, 12'h021, 1'b0, 1'b1);
    checks++; if (zero_o !== 1'b0 || carry_o !== 1'b1 || stk_o !== 12'h021) begin
      errors++; $display("FAIL flags_repl: got z=%b c=%b pc=%h expected 0 1 021", zero_o, carry_o, stk_o);
    end
`endif
  endtask

  task automatic test_random();
    int bias;
    logic [13:0] t;
    logic rst, push, pop, z, c;
    pc_t d;
    step(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    for (int n = 0; n < 600; n++) begin
      // Alternate fill-heavy and drain-heavy phases to reach both boundaries.
      bias = ((n / 60) % 2 == 0) ? 75 : 25;
      rst  = ($urandom_range(0, 99) < 2);
      push = ($urandom_range(0, 99) < bias);
      pop  = ($urandom_range(0, 99) < (100 - bias));
      d    = 12'($urandom);
      z    = 1'($urandom);
      c    = 1'($urandom);
      step(rst, push, pop, d, z, c);
      t = m_top();
      checks++;
      if (stk_o !== t[11:0] || depth_o !== DW'(m_q.size()) ||
          empty_o !== (m_q.size() == 0) || full_o !== (m_q.size() == DEPTH) ||
          overflow_o !== m_ovf || underflow_o !== m_unf) begin
        errors++;
        $display("FAIL rand_%0d: got stk=%h d=%0d e=%b f=%b o=%b u=%b expected stk=%h d=%0d e=%b f=%b o=%b u=%b",
                 n, stk_o, depth_o, empty_o, full_o, overflow_o, underflow_o,
                 t[11:0], m_q.size(), (m_q.size() == 0), (m_q.size() == DEPTH), m_ovf, m_unf);
      end
`ifdef CALL_STACK_FLAGS_EN
      checks++;
      if (zero_o !== t[13] || carry_o !== t[12]) begin
        errors++; $display("FAIL rand_flags_%0d: got z=%b c=%b expected %b %b", n, zero_o, carry_o, t[13], t[12]);
      end
`endif
    end
  endtask

  initial begin
    rst_i       = 1'b1;
    push_i      = 1'b0;
    pop_i       = 1'b0;
    push_data_i = '0;
`ifdef CALL_STACK_FLAGS_EN
    zero_i      = 1'b0;
    carry_i     = 1'b0;
`endif
    m_ovf = 1'b0;
    m_unf = 1'b0;
    test_reset();
    test_push_pop_order();
    test_fill_overflow();
    test_underflow();
    test_simultaneous();
    test_reset_mid_op();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/call_stack.md
Name: call_stack

Overview:
- LIFO return-address stack for the processor's program-counter path.
- Sits directly upstream of the next-PC logic: its top-of-stack output drives that block's stk_i return-address input.
- Pushes the return address on CALL/interrupt and pops it on RETURN/RETURNI.
- Tracks depth and reports overflow/underflow as sticky error flags.

Parameters:
- PC_W, 12, width of a program address.
- DEPTH, 16, number of stack entries (2..64).

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- push_i  in  1  push push_data_i (CALL / interrupt entry).
- pop_i  in  1  pop top entry (RETURN / RETURNI).
- push_data_i  in  PC_W  return address to save (current PC + 1 for CALL, current PC for interrupt).
- stk_o  out  PC_W  top-of-stack address, to next-PC stk_i.
- empty_o  out  1  no valid entries.
- full_o  out  1  DEPTH entries held.
- depth_o  out  $clog2(DEPTH+1)  current entry count.
- overflow_o  out  1  sticky: push attempted while full.
- underflow_o  out  1  sticky: pop attempted while empty.

Behaviour:
- State: pointer sp holds 0..DEPTH and equals the entry count; storage is entry array mem[0..DEPTH-1].
- Reset (rst_i high at a clock edge, mid-operation included): sp=0, overflow_o=0, underflow_o=0. stk_o=0, empty_o=1, full_o=0, depth_o=0. Array contents are not cleared. A push/pop in the same cycle as reset is discarded.
- All updates occur at the rising edge; outputs reflect the new state the cycle after the operation, so latency is 1. stk_o is combinational from sp and mem: mem[sp-1] when sp>0, else 0.
- Operation table, (push_i,pop_i):
  - (0,0): hold.
  - (1,0), not full: mem[sp]<=push_data_i; sp<=sp+1.
  - (1,0), full: no write, sp unchanged, overflow_o<=1.
  - (0,1), not empty: sp<=sp-1. Entry data is left in place.
  - (0,1), empty: sp unchanged, underflow_o<=1.
  - (1,1), not empty: replace top, mem[sp-1]<=push_data_i; sp unchanged; no flag.
  - (1,1), empty: treated as a plain push; no underflow.
- Boundaries:
  - full_o = (sp==DEPTH); empty_o = (sp==0).
  - No wrap-around: an overflowing push never corrupts existing entries.
  - Sticky flags clear only on rst_i.
- Purely counter/register-file sequential logic; no FSM beyond the pointer.

Optional Feature:
- Macro: CALL_STACK_FLAGS_EN.
- Defined:
  - Each entry widens to PC_W+2 and also stores zero_i/carry_i.
  - Added ports: zero_i in 1, carry_i in 1, zero_o out 1, carry_o out 1. zero_o/carry_o are the flag bits of the top entry.
  - Supports RETURNI restoring the ALU flags. zero_o/carry_o=0 when empty and on reset.
  - Replace (1,1) also replaces the stored flags.
- Undefined: entries are PC_W bits, and the four flag ports do not exist.

Decomposition:
- Shared package pc_pkg holds:
  - localparam PC_W=12 and STK_DEPTH=16.
  - typedef logic [PC_W-1:0] pc_t.
  - enum stk_op_e {STK_NOP, STK_PUSH, STK_POP, STK_REPL}, decoded from push_i/pop_i and reused by the PC-operation decoder.
- One natural sub-module: call_stack_mem, a DEPTH x width register file with one synchronous write port and one asynchronous read port. call_stack keeps the pointer, flags and op decode.

Test Plan:
- Reset then idle:
  - Stimulus: rst_i=1 for 2 cycles, then release.
  - Required: stk_o=0x000, empty_o=1, depth_o=0, both error flags 0.
- Push/pop order:
  - Stimulus: push 0x002, 0x007, 0x10A on consecutive cycles, then pop 3 times.
  - Required after pushes: stk_o=0x10A, depth_o=3.
  - Required after the pops: stk_o reads 0x007, 0x002, then 0x000 with empty_o=1.
- Fill and overflow:
  - Stimulus: push 0x001..0x010 (16 entries), then push 0x0FF.
  - Required: full_o=1 after the 16th push. After 0x0FF: overflow_o=1, stk_o stays 0x010, depth_o stays 16.
- Underflow:
  - Stimulus: pop while empty.
  - Required: underflow_o=1 next cycle, depth_o=0. Flag holds through later pushes until rst_i.
- Simultaneous push+pop:
  - Stimulus: with stack [0x002,0x007], push_i=pop_i=1 and push_data_i=0x3FF.
  - Required: stk_o=0x3FF, depth_o=2. Same op while empty gives depth_o=1 and no underflow.
- Reset mid-operation:
  - Stimulus: depth 5, then assert rst_i together with push_i.
  - Required: depth_o=0, empty_o=1, no entry added.
  - With CALL_STACK_FLAGS_EN: push 0x020 with zero_i=1, carry_i=0, then read. Required: zero_o=1, carry_o=0.
